// File: rtl/img_filter_reg_pkg.sv
// img_filter_reg_pkg: filter register map, sequencer states and error codes shared by master and slave.
package img_filter_reg_pkg;
    localparam logic [7:0] REG_ID           = 8'h00;
    localparam logic [7:0] REG_CTL_CONTROL  = 8'h04;
    localparam logic [7:0] REG_PARAM_ENABLE = 8'h08;
    localparam int         CTL_UPDATE_BIT   = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_WR_PARAM,
        ST_WR_CTL,
        ST_POLL
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ID      = 2'd1,
        ERR_BUS     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } seq_err_t;

    // Register offsets are in 32-bit words; the bus is byte addressed.
    function automatic logic [9:0] reg_byte_off(input logic [7:0] word_off);
        return {word_off, 2'b00};
    endfunction
endpackage

// File: rtl/axi4l_single_master.sv
// axi4l_single_master: issues one AXI4-Lite read or write per request and acks on the response handshake.
module axi4l_single_master #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_req,
    input  logic                   i_we,
    input  logic [ADDR_BITS-1:0]   i_addr,
    input  logic [DATA_BITS-1:0]   i_wdata,
    output logic                   o_ack,
    output logic [1:0]             o_resp,
    output logic [DATA_BITS-1:0]   o_rdata,
    output logic [ADDR_BITS-1:0]   m_axi4l_awaddr,
    output logic [2:0]             m_axi4l_awprot,
    output logic                   m_axi4l_awvalid,
    input  logic                   m_axi4l_awready,
    output logic [DATA_BITS-1:0]   m_axi4l_wdata,
    output logic [DATA_BITS/8-1:0] m_axi4l_wstrb,
    output logic                   m_axi4l_wvalid,
    input  logic                   m_axi4l_wready,
    input  logic [1:0]             m_axi4l_bresp,
    input  logic                   m_axi4l_bvalid,
    output logic                   m_axi4l_bready,
    output logic [ADDR_BITS-1:0]   m_axi4l_araddr,
    output logic [2:0]             m_axi4l_arprot,
    output logic                   m_axi4l_arvalid,
    input  logic                   m_axi4l_arready,
    input  logic [DATA_BITS-1:0]   m_axi4l_rdata,
    input  logic [1:0]             m_axi4l_rresp,
    input  logic                   m_axi4l_rvalid,
    output logic                   m_axi4l_rready
);
    logic                 r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic [ADDR_BITS-1:0] r_awaddr, r_araddr;
    logic [DATA_BITS-1:0] r_wdata;
    logic                 w_aw_hold, w_w_hold, w_b_hs, w_r_hs, w_wr_req, w_rd_req;

    assign w_aw_hold = r_awvalid & ~m_axi4l_awready;
    assign w_w_hold  = r_wvalid & ~m_axi4l_wready;
    assign w_b_hs    = r_bready & m_axi4l_bvalid;
    assign w_r_hs    = r_rready & m_axi4l_rvalid;
    assign w_wr_req  = i_req & i_we;
    assign w_rd_req  = i_req & ~i_we;

    // AW and W retire independently; BREADY opens once neither is still pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_wdata   <= '0;
        end else begin
            r_awvalid <= w_wr_req | w_aw_hold;
            r_wvalid  <= w_wr_req | w_w_hold;
            r_bready  <= w_b_hs ? 1'b0 : (r_bready | ((r_awvalid | r_wvalid) & ~w_aw_hold & ~w_w_hold));
            r_arvalid <= w_rd_req | (r_arvalid & ~m_axi4l_arready);
            r_rready  <= w_r_hs ? 1'b0 : (r_rready | (r_arvalid & m_axi4l_arready));
            if (w_wr_req) begin
                r_awaddr <= i_addr;
                r_wdata  <= i_wdata;
            end
            if (w_rd_req) r_araddr <= i_addr;
        end
    end

    assign o_ack           = w_b_hs | w_r_hs;
    assign o_resp          = r_bready ? m_axi4l_bresp : m_axi4l_rresp;
    assign o_rdata         = m_axi4l_rdata;
    assign m_axi4l_awaddr  = r_awaddr;
    assign m_axi4l_awprot  = 3'b000;
    assign m_axi4l_awvalid = r_awvalid;
    assign m_axi4l_wdata   = r_wdata;
    assign m_axi4l_wstrb   = '1;
    assign m_axi4l_wvalid  = r_wvalid;
    assign m_axi4l_bready  = r_bready;
    assign m_axi4l_araddr  = r_araddr;
    assign m_axi4l_arprot  = 3'b000;
    assign m_axi4l_arvalid = r_arvalid;
    assign m_axi4l_rready  = r_rready;
endmodule

// File: rtl/axi4l_param_sequencer.sv
// axi4l_param_sequencer: checks the filter ID, writes PARAM_ENABLE and CTL_CONTROL, then polls for update completion.
module axi4l_param_sequencer
    import img_filter_reg_pkg::*;
#(
    parameter int                   NUM        = 1,
    parameter int                   ADDR_BITS  = 32,
    parameter int                   DATA_BITS  = 32,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR  = '0,
    parameter logic [DATA_BITS-1:0] CORE_ID    = 32'h5254_437f,
    parameter int                   POLL_LIMIT = 1023
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic                   start,
    input  logic                   ctl_enable,
    input  logic [NUM-1:0]         param_enable,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             error,
    output logic [ADDR_BITS-1:0]   m_axi4l_awaddr,
    output logic [2:0]             m_axi4l_awprot,
    output logic                   m_axi4l_awvalid,
    input  logic                   m_axi4l_awready,
    output logic [DATA_BITS-1:0]   m_axi4l_wdata,
    output logic [DATA_BITS/8-1:0] m_axi4l_wstrb,
    output logic                   m_axi4l_wvalid,
    input  logic                   m_axi4l_wready,
    input  logic [1:0]             m_axi4l_bresp,
    input  logic                   m_axi4l_bvalid,
    output logic                   m_axi4l_bready,
    output logic [ADDR_BITS-1:0]   m_axi4l_araddr,
    output logic [2:0]             m_axi4l_arprot,
    output logic                   m_axi4l_arvalid,
    input  logic                   m_axi4l_arready,
    input  logic [DATA_BITS-1:0]   m_axi4l_rdata,
    input  logic [1:0]             m_axi4l_rresp,
    input  logic                   m_axi4l_rvalid,
    output logic                   m_axi4l_rready
);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    seq_state_t           r_state, w_next;
    seq_err_t             r_error;
    logic                 r_done, r_ctl_en;
    logic [NUM-1:0]       r_param;
    logic [PW-1:0]        r_poll_cnt;
    logic                 w_start_ok, w_ack, w_req, w_we, w_resp_err, w_poll_last, w_id_bad;
    logic [1:0]           w_resp;
    logic [7:0]           w_reg;
    logic [ADDR_BITS-1:0] w_addr;
    logic [DATA_BITS-1:0] w_wdata, w_rdata;

    assign w_start_ok  = (r_state == ST_IDLE) & start;
    assign w_resp_err  = w_ack & (w_resp != 2'b00);
    assign w_id_bad    = w_rdata != CORE_ID;
    assign w_poll_last = r_poll_cnt == PW'(POLL_LIMIT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     w_next = start ? ST_RD_ID : ST_IDLE;
            ST_RD_ID:    if (w_ack) w_next = (w_resp_err | w_id_bad) ? ST_IDLE : ST_WR_PARAM;
            ST_WR_PARAM: if (w_ack) w_next = w_resp_err ? ST_IDLE : ST_WR_CTL;
            ST_WR_CTL:   if (w_ack) w_next = w_resp_err ? ST_IDLE : ST_POLL;
            ST_POLL:     if (w_ack) w_next = (w_resp_err | ~w_rdata[CTL_UPDATE_BIT] | w_poll_last) ? ST_IDLE : ST_POLL;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Each transaction is launched on the edge that enters its state, saving a cycle per step.
    always_comb begin
        w_req   = w_start_ok | (w_ack & (w_next != ST_IDLE));
        w_we    = (w_next == ST_WR_PARAM) | (w_next == ST_WR_CTL);
        w_reg   = (w_next == ST_WR_PARAM) ? REG_PARAM_ENABLE : (w_next == ST_RD_ID) ? REG_ID : REG_CTL_CONTROL;
        w_addr  = BASE_ADDR + ADDR_BITS'(reg_byte_off(w_reg));
        w_wdata = (w_next == ST_WR_PARAM) ? DATA_BITS'(r_param) : DATA_BITS'({1'b1, r_ctl_en});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error    <= ERR_NONE;
            r_done     <= 1'b0;
            r_ctl_en   <= 1'b0;
            r_param    <= '0;
            r_poll_cnt <= '0;
        end else begin
            r_done <= (r_state == ST_POLL) & w_ack & ~w_resp_err & ~w_rdata[CTL_UPDATE_BIT];
            if (w_start_ok) begin
                r_error    <= ERR_NONE;
                r_ctl_en   <= ctl_enable;
                r_param    <= param_enable;
                r_poll_cnt <= '0;
            end else if (w_resp_err) begin
                r_error <= ERR_BUS;
            end else if ((r_state == ST_RD_ID) & w_ack & w_id_bad) begin
                r_error <= ERR_ID;
            end else if ((r_state == ST_POLL) & w_ack & w_rdata[CTL_UPDATE_BIT]) begin
                r_poll_cnt <= r_poll_cnt + 1'b1;
                if (w_poll_last) r_error <= ERR_TIMEOUT;
            end
        end
    end

    assign busy  = r_state != ST_IDLE;
    assign done  = r_done;
    assign error = r_error;

    axi4l_single_master #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS)
    ) u_master (
        .clk             (clk),
        .reset           (reset),
        .i_req           (w_req),
        .i_we            (w_we),
        .i_addr          (w_addr),
        .i_wdata         (w_wdata),
        .o_ack           (w_ack),
        .o_resp          (w_resp),
        .o_rdata         (w_rdata),
        .m_axi4l_awaddr  (m_axi4l_awaddr),
        .m_axi4l_awprot  (m_axi4l_awprot),
        .m_axi4l_awvalid (m_axi4l_awvalid),
        .m_axi4l_awready (m_axi4l_awready),
        .m_axi4l_wdata   (m_axi4l_wdata),
        .m_axi4l_wstrb   (m_axi4l_wstrb),
        .m_axi4l_wvalid  (m_axi4l_wvalid),
        .m_axi4l_wready  (m_axi4l_wready),
        .m_axi4l_bresp   (m_axi4l_bresp),
        .m_axi4l_bvalid  (m_axi4l_bvalid),
        .m_axi4l_bready  (m_axi4l_bready),
        .m_axi4l_araddr  (m_axi4l_araddr),
        .m_axi4l_arprot  (m_axi4l_arprot),
        .m_axi4l_arvalid (m_axi4l_arvalid),
        .m_axi4l_arready (m_axi4l_arready),
        .m_axi4l_rdata   (m_axi4l_rdata),
        .m_axi4l_rresp   (m_axi4l_rresp),
        .m_axi4l_rvalid  (m_axi4l_rvalid),
        .m_axi4l_rready  (m_axi4l_rready)
    );
endmodule

// File: tb/tb_axi4l_param_sequencer.sv
// tb_axi4l_param_sequencer: directed bench with a behavioural filter-register slave and bus monitor.
module tb_axi4l_param_sequencer;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] CID  = 32'h5254_437f;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, ctl_enable = 1'b0, clr = 1'b0;
    logic [0:0] param_enable = 1'b0;
    logic busy, done;
    logic [1:0] error, bresp, rresp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0] awprot, arprot;
    logic [3:0] wstrb;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;

    int aw_delay = 0, clear_at = 2;
    logic [31:0] id_value = CID;
    logic bresp_param = 1'b0;

    int n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    axi4l_param_sequencer #(
        .NUM(1), .ADDR_BITS(32), .DATA_BITS(32), .BASE_ADDR(BASE), .CORE_ID(CID), .POLL_LIMIT(4)
    ) dut (
        .reset(reset), .clk(clk), .start(start), .ctl_enable(ctl_enable), .param_enable(param_enable),
        .busy(busy), .done(done), .error(error),
        .m_axi4l_awaddr(awaddr), .m_axi4l_awprot(awprot), .m_axi4l_awvalid(awvalid), .m_axi4l_awready(awready),
        .m_axi4l_wdata(wdata), .m_axi4l_wstrb(wstrb), .m_axi4l_wvalid(wvalid), .m_axi4l_wready(wready),
        .m_axi4l_bresp(bresp), .m_axi4l_bvalid(bvalid), .m_axi4l_bready(bready),
        .m_axi4l_araddr(araddr), .m_axi4l_arprot(arprot), .m_axi4l_arvalid(arvalid), .m_axi4l_arready(arready),
        .m_axi4l_rdata(rdata), .m_axi4l_rresp(rresp), .m_axi4l_rvalid(rvalid), .m_axi4l_rready(rready)
    );

    // Slave: AWREADY after aw_delay waiting cycles, B after both AW and W land, R one cycle after AR.
    int aw_cnt, poll_n;
    logic aw_got, w_got;
    logic [31:0] aw_a, w_d;
    logic [3:0] w_s;
    assign awready = aw_cnt >= aw_delay;
    assign wready  = 1'b1;
    assign arready = 1'b1;
    assign rresp   = 2'b00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_cnt <= 0; poll_n <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_a <= '0; w_d <= '0; w_s <= '0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0;
        end else begin
            if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; aw_cnt <= 0; end
            else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready) begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; end
            if (aw_got && w_got && !bvalid) begin
                bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
                bresp <= (bresp_param && aw_a == BASE + 32'h20) ? 2'd2 : 2'd0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                if (araddr == BASE) rdata <= id_value;
                else begin
                    poll_n <= poll_n + 1;
                    rdata <= (clear_at != 0 && poll_n + 1 >= clear_at) ? 32'h0 : 32'h2;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (clr) poll_n <= 0;
        end
    end

    int wr_n, id_reads, ctl_reads, done_cnt, b_hs, aw_hi, w_hi, stab_err, ar_n;
    logic [31:0] wr_addr [4];
    logic [31:0] wr_dat [4];
    logic [3:0]  wr_strb [4];
    logic [31:0] first_ar, aw_prev;
    logic aw_wait;

    always @(posedge clk) begin
        if (clr || reset) begin
            wr_n <= 0; id_reads <= 0; ctl_reads <= 0; done_cnt <= 0; b_hs <= 0;
            aw_hi <= 0; w_hi <= 0; stab_err <= 0; ar_n <= 0; first_ar <= '1; aw_wait <= 1'b0; aw_prev <= '0;
        end else begin
            if (aw_got && w_got && !bvalid) begin
                if (wr_n < 4) begin wr_addr[wr_n] <= aw_a; wr_dat[wr_n] <= w_d; wr_strb[wr_n] <= w_s; end
                wr_n <= wr_n + 1;
            end
            if (arvalid && arready) begin
                if (ar_n == 0) first_ar <= araddr;
                ar_n <= ar_n + 1;
                if (araddr == BASE) id_reads <= id_reads + 1;
                if (araddr == BASE + 32'h10) ctl_reads <= ctl_reads + 1;
            end
            done_cnt <= done_cnt + int'(done);
            b_hs     <= b_hs + int'(bvalid && bready);
            aw_hi    <= aw_hi + int'(awvalid);
            w_hi     <= w_hi + int'(wvalid);
            aw_wait  <= awvalid && !awready;
            aw_prev  <= awaddr;
            if (aw_wait && awaddr != aw_prev) stab_err <= stab_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_clr;
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic run(input logic ce, input logic pe);
        @(negedge clk);
        start = 1'b1; ctl_enable = ce; param_enable = pe;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        chk("idle_timeout", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({busy, done, error, awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        chk("reset_addr", {awaddr, araddr}, 64'd0);
        chk("reset_wdata", 64'(wdata), 64'd0);
        chk("prot_zero", 64'({awprot, arprot}), 64'd0);
        reset = 1'b0;

        // Nominal sequence; a second start mid-run with ctl_enable=0 must be ignored.
        clear_at = 2;
        pulse_clr;
        run(1'b1, 1'b1);
        chk("busy_after_start", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        start = 1'b1; ctl_enable = 1'b0; param_enable = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_idle;
        chk("nom_wr_n", 64'(wr_n), 64'd2);
        chk("nom_wr0_addr", 64'(wr_addr[0]), 64'(BASE + 32'h20));
        chk("nom_wr0_data", 64'(wr_dat[0]), 64'h1);
        chk("nom_wr0_strb", 64'(wr_strb[0]), 64'hf);
        chk("nom_wr1_addr", 64'(wr_addr[1]), 64'(BASE + 32'h10));
        chk("nom_wr1_data", 64'(wr_dat[1]), 64'h3);
        chk("nom_ctl_reads", 64'(ctl_reads), 64'd2);
        chk("nom_id_reads", 64'(id_reads), 64'd1);
        chk("nom_done_cnt", 64'(done_cnt), 64'd1);
        chk("nom_error", 64'(error), 64'd0);

        // Minimum latency with first-poll success.
        clear_at = 1;
        pulse_clr;
        @(negedge clk);
        start = 1'b1; ctl_enable = 1'b0; param_enable = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) break;
        end
        chk("latency_le_12", 64'(lat <= 12), 64'd1);
        chk("lat_busy_with_done", 64'(busy), 64'd0);
        wait_idle;
        chk("lat_wr0_data", 64'(wr_dat[0]), 64'h0);
        chk("lat_wr1_data", 64'(wr_dat[1]), 64'h2);
        chk("lat_done_cnt", 64'(done_cnt), 64'd1);

        // Wrong ID.
        id_value = 32'h1234_5678;
        pulse_clr;
        run(1'b1, 1'b1);
        wait_idle;
        chk("id_wr_n", 64'(wr_n), 64'd0);
        chk("id_aw_hi", 64'(aw_hi), 64'd0);
        chk("id_error", 64'(error), 64'd1);
        chk("id_done_cnt", 64'(done_cnt), 64'd0);
        id_value = CID;

        // Update bit never clears.
        clear_at = 0;
        pulse_clr;
        run(1'b1, 1'b1);
        wait_idle;
        chk("to_ctl_reads", 64'(ctl_reads), 64'd4);
        chk("to_error", 64'(error), 64'd3);
        chk("to_done_cnt", 64'(done_cnt), 64'd0);
        chk("to_wr_n", 64'(wr_n), 64'd2);

        // Slow AWREADY.
        clear_at = 1; aw_delay = 3;
        pulse_clr;
        run(1'b1, 1'b1);
        wait_idle;
        chk("slow_aw_stable", 64'(stab_err), 64'd0);
        chk("slow_w_hi", 64'(w_hi), 64'd2);
        chk("slow_aw_hi", 64'(aw_hi), 64'd8);
        chk("slow_b_hs", 64'(b_hs), 64'd2);
        chk("slow_wr1_data", 64'(wr_dat[1]), 64'h3);
        chk("slow_done_cnt", 64'(done_cnt), 64'd1);
        chk("slow_error", 64'(error), 64'd0);
        aw_delay = 0;

        // Bus error on the PARAM_ENABLE write.
        bresp_param = 1'b1;
        pulse_clr;
        run(1'b1, 1'b1);
        wait_idle;
        chk("berr_error", 64'(error), 64'd2);
        chk("berr_wr_n", 64'(wr_n), 64'd1);
        chk("berr_aw_hi", 64'(aw_hi), 64'd1);
        chk("berr_ctl_reads", 64'(ctl_reads), 64'd0);
        chk("berr_done_cnt", 64'(done_cnt), 64'd0);
        bresp_param = 1'b0;

        // Reset during the CTL_CONTROL write, then restart.
        clear_at = 2;
        pulse_clr;
        run(1'b1, 1'b1);
        chk("error_cleared_on_start", 64'(error), 64'd0);
        for (int i = 0; i < 50; i++) begin
            if (awvalid && awaddr == BASE + 32'h10) break;
            @(negedge clk);
        end
        chk("reach_wr_ctl", 64'(awvalid && awaddr == BASE + 32'h10), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_ctrl", 64'({busy, done, error, awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        chk("midrst_addr", {awaddr, araddr}, 64'd0);
        chk("midrst_wdata", 64'(wdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        pulse_clr;
        run(1'b1, 1'b0);
        wait_idle;
        chk("rst_first_ar", 64'(first_ar), 64'(BASE));
        chk("rst_id_reads", 64'(id_reads), 64'd1);
        chk("rst_wr0_data", 64'(wr_dat[0]), 64'h0);
        chk("rst_done_cnt", 64'(done_cnt), 64'd1);
        chk("rst_error", 64'(error), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
